input_port_controller: RTL and testbench

Per-port ingress stage of the mesh router, one instance per input, feeding SwitchControl and the crossbar. It buffers incoming flits in a small FIFO and computes the dimension-ordered output port from the head flit. It reserves that port through the routeReserve handshake, streams the packet to the crossbar, and releases the path after the tail flit. The router instantiates SwitchControl with INPUTS = OUTPUTS = 5 and REQUEST_WIDTH = 3.

---
 rtl/noc_pkg.sv | 59 +++++
 rtl/flit_fifo.sv | 51 +++++
 rtl/input_port_controller.sv | 130 +++++++++++++
 tb/tb_input_port_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ==========================================================================
// noc_pkg : shared flit types, port codes, state encoding and route function
// Revision 1.0
// ==========================================================================
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_FORWARD = 2'd2,
    ST_RELIEVE = 2'd3
  } ipc_state_e;

  localparam logic [2:0] c_port_local = 3'd0;
  localparam logic [2:0] c_port_east  = 3'd1;
  localparam logic [2:0] c_port_west  = 3'd2;
  localparam logic [2:0] c_port_north = 3'd3;
  localparam logic [2:0] c_port_south = 3'd4;

  function automatic int flit_width(input int data_width);
    return data_width + 2;
  endfunction

  // HEAD and HEADTAIL share bit 0; TAIL and HEADTAIL share bit 1.
  function automatic logic is_head(input logic [1:0] ftype);
    return ftype[0];
  endfunction

  function automatic logic is_tail(input logic [1:0] ftype);
    return ftype[1];
  endfunction

  // Dimension-ordered route; yx_first resolves the Y dimension before X.
  function automatic logic [2:0] route(input int unsigned dx, input int unsigned dy,
                                       input int unsigned rx, input int unsigned ry,
                                       input logic yx_first);
    logic [2:0] x_port;
    logic [2:0] y_port;
    logic [2:0] result;
    x_port = (dx > rx) ? c_port_east  : (dx < rx) ? c_port_west  : c_port_local;
    y_port = (dy > ry) ? c_port_north : (dy < ry) ? c_port_south : c_port_local;
    if (yx_first) begin
      result = (y_port != c_port_local) ? y_port : x_port;
    end else begin
      result = (x_port != c_port_local) ? x_port : y_port;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ==========================================================================
// flit_fifo : circular flit buffer with wrap-bit pointers, head output
// Revision 1.0
// ==========================================================================
module flit_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  // Equal indices with differing wrap bits means the writer lapped the reader.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                  (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign head   = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/input_port_controller.sv
`default_nettype none
// ==========================================================================
// input_port_controller : router ingress buffer, route, reserve, stream, release
// Revision 1.0 | IPC_YX_ROUTING_EN selects Y-first instead of X-first routing
// ==========================================================================
module input_port_controller
  import noc_pkg::*;
#(
  parameter int N             = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int REQUEST_WIDTH = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [flit_width(DATA_WIDTH)-1:0]  in_flit,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [flit_width(DATA_WIDTH)-1:0]  out_flit,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0]           routeReserveRequest,
  output logic                               routeRelieve,
  input  logic                               routeReserveStatus,
  input  logic                               PortReserved,
  output logic                               flitDropped
);

  localparam int c_cw = $clog2(N);
  localparam int c_fw = flit_width(DATA_WIDTH);
`ifdef IPC_YX_ROUTING_EN
  localparam logic c_yx_first = 1'b1;
`else
  localparam logic c_yx_first = 1'b0;
`endif

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_fwd_pop;
  logic               w_drop_pop;
  logic [c_fw-1:0]    w_head;
  logic [1:0]         w_head_type;
  logic [c_cw-1:0]    w_dx;
  logic [c_cw-1:0]    w_dy;
  logic [2:0]         w_route;

  ipc_state_e               r_state;
  logic                     r_req_valid;
  logic [REQUEST_WIDTH-1:0] r_request;
  logic                     r_relieve;
  logic                     r_dropped;

  flit_fifo #(
    .WIDTH (c_fw),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_flit),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign w_head_type = w_head[c_fw-1:DATA_WIDTH];
  assign w_dx        = w_head[2*c_cw-1:c_cw];
  assign w_dy        = w_head[c_cw-1:0];
  assign w_route     = route(32'(w_dx), 32'(w_dy), ROUTER_X, ROUTER_Y, c_yx_first);

  assign in_ready   = ~w_full;
  assign w_push     = in_valid & ~w_full;
  assign out_flit   = w_head;
  assign out_valid  = (r_state == ST_FORWARD) & PortReserved & ~w_empty;
  assign w_fwd_pop  = out_valid & out_ready;
  // A non-head flit at the head while idle belongs to no packet; discard it.
  assign w_drop_pop = (r_state == ST_IDLE) & ~w_empty & ~is_head(w_head_type);
  assign w_pop      = w_fwd_pop | w_drop_pop;

  assign routeReserveRequestValid = r_req_valid;
  assign routeReserveRequest      = r_request;
  assign routeRelieve             = r_relieve;
  assign flitDropped              = r_dropped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_request   <= '0;
      r_relieve   <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_relieve <= 1'b0;
      r_dropped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (is_head(w_head_type)) begin
              r_request   <= REQUEST_WIDTH'(w_route);
              r_req_valid <= 1'b1;
              r_state     <= ST_REQUEST;
            end else begin
              r_dropped <= 1'b1;
            end
          end
        end
        ST_REQUEST: begin
          if (routeReserveStatus) r_state <= ST_FORWARD;
        end
        ST_FORWARD: begin
          if (w_fwd_pop && is_tail(w_head_type)) begin
            r_req_valid <= 1'b0;
            r_relieve   <= 1'b1;
            r_state     <= ST_RELIEVE;
          end
        end
        ST_RELIEVE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port_controller.sv
`default_nettype none
// ==========================================================================
// tb_input_port_controller : directed and randomized checks, router at (1,1)
// Revision 1.0
// ==========================================================================
module tb_input_port_controller;

  localparam int RX = 1;
  localparam int RY = 1;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int FW = DW + 2;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          routeReserveRequestValid;
  logic [2:0]    routeReserveRequest;
  logic          routeRelieve;
  logic          routeReserveStatus = 1'b0;
  logic          PortReserved = 1'b0;
  logic          flitDropped;

  int n_cmp  = 0;
  int n_fail = 0;
  int sw_wait = 0;
  logic sw_busy = 1'b0;

  input_port_controller #(
    .N(4), .ROUTER_X(RX), .ROUTER_Y(RY), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .REQUEST_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .routeReserveRequestValid(routeReserveRequestValid), .routeReserveRequest(routeReserveRequest),
    .routeRelieve(routeRelieve), .routeReserveStatus(routeReserveStatus),
    .PortReserved(PortReserved), .flitDropped(flitDropped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Switch-control stand-in: grant pulse in the third request cycle, then hold the path.
  task automatic stub_update();
    if (!rst) begin
      routeReserveStatus = 1'b0; PortReserved = 1'b0; sw_wait = 0; sw_busy = 1'b0;
      return;
    end
    if (routeReserveStatus) begin routeReserveStatus = 1'b0; PortReserved = 1'b1; end
    if (routeRelieve) begin PortReserved = 1'b0; sw_busy = 1'b0; end
    if (routeReserveRequestValid && !sw_busy) begin
      sw_wait++;
      if (sw_wait == 3) begin routeReserveStatus = 1'b1; sw_busy = 1'b1; sw_wait = 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; stub_update(); #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_flit = '0; out_ready = 1'b0; rst = 1'b0;
    stub_update();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  function automatic int ref_route(input int dx, input int dy);
    int xp, yp;
    xp = (dx > RX) ? 1 : (dx < RX) ? 2 : 0;
    yp = (dy > RY) ? 3 : (dy < RY) ? 4 : 0;
`ifdef IPC_YX_ROUTING_EN
    return (yp != 0) ? yp : xp;
`else
    return (xp != 0) ? xp : yp;
`endif
  endfunction

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0; #1;
    stub_update(); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (routeReserveRequestValid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", routeReserveRequestValid); end
    n_cmp++; if (routeReserveRequest !== 3'd0) begin n_fail++; $display("FAIL reset_request: got %0d want 0", routeReserveRequest); end
    n_cmp++; if (routeRelieve !== 1'b0 || flitDropped !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got relieve=%b dropped=%b want 0 0", routeRelieve, flitDropped); end
    rst = 1'b1; tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_latency();
    int first_valid = -1;
    int rel_cyc = -1;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0); in_flit = {T_HT, 8'h0D};
      if (c == 2) begin
        n_cmp++;
        if (routeReserveRequestValid !== 1'b1 || routeReserveRequest !== 3'd1) begin
          n_fail++; $display("FAIL latency_request: got valid=%b req=%0d want 1 1", routeReserveRequestValid, routeReserveRequest);
        end
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (routeRelieve && rel_cyc < 0) rel_cyc = c;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (first_valid != 5) begin n_fail++; $display("FAIL latency_out_valid: got cycle %0d want 5", first_valid); end
    n_cmp++; if (rel_cyc != 6) begin n_fail++; $display("FAIL latency_relieve: got cycle %0d want 6", rel_cyc); end
  endtask

  task automatic test_packet();
    logic [FW-1:0] pkt[3];
    int npop = 0, last_pop = -1, rel_cyc = -1, nrel = 0, req = -1;
    logic consec = 1'b1;
    pkt[0] = {T_HEAD, 8'h05}; pkt[1] = {T_BODY, 8'hA5}; pkt[2] = {T_TAIL, 8'h3C};
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 3); in_flit = pkt[(c < 3) ? c : 2];
      if (routeReserveRequestValid && req < 0) req = int'(routeReserveRequest);
      if (routeRelieve) begin
        nrel++; rel_cyc = c;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL packet_valid_at_relieve: got %b want 0", out_valid); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (npop >= 3 || out_flit !== pkt[(npop < 3) ? npop : 0]) begin
          n_fail++; $display("FAIL packet_flit: got %h want %h (index %0d)", out_flit, pkt[(npop < 3) ? npop : 0], npop);
        end
        if (npop > 0 && c != last_pop + 1) consec = 1'b0;
        last_pop = c; npop++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (req != 0) begin n_fail++; $display("FAIL packet_route: got %0d want 0", req); end
    n_cmp++; if (npop != 3 || !consec) begin n_fail++; $display("FAIL packet_stream: got %0d pops consecutive=%b want 3 1", npop, consec); end
    n_cmp++; if (nrel != 1 || rel_cyc != last_pop + 1) begin n_fail++; $display("FAIL packet_relieve: got count=%0d cycle=%0d want 1 at %0d", nrel, rel_cyc, last_pop + 1); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL packet_idle_after: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_stray();
    int drops = 0;
    logic req_seen = 1'b0;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0); in_flit = {T_BODY, 8'h77};
      if (flitDropped) drops++;
      if (routeReserveRequestValid) req_seen = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (drops != 1) begin n_fail++; $display("FAIL stray_drop_count: got %0d want 1", drops); end
    n_cmp++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL stray_request: got %b want 0", req_seen); end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stray_empty: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_full();
    logic [FW-1:0] f[5];
    int idx = 0, npop = 0, first_pop = -1, accept5 = -1;
    f[0] = {T_HEAD, 8'h05}; f[1] = {T_BODY, 8'h11}; f[2] = {T_BODY, 8'h22};
    f[3] = {T_BODY, 8'h33}; f[4] = {T_TAIL, 8'h44};
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 5); in_flit = f[(idx < 5) ? idx : 4];
      out_ready = (c >= 10);
      if (c == 4) begin
        n_cmp++; if (in_ready !== 1'b0 || idx != 4) begin n_fail++; $display("FAIL full_in_ready: got in_ready=%b accepted=%0d want 0 4", in_ready, idx); end
      end
      if (in_valid && in_ready) begin
        if (idx == 4) accept5 = c;
        idx++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (npop >= 5 || out_flit !== f[(npop < 5) ? npop : 0]) begin
          n_fail++; $display("FAIL full_flit: got %h want %h (index %0d)", out_flit, f[(npop < 5) ? npop : 0], npop);
        end
        if (first_pop < 0) first_pop = c;
        npop++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (first_pop < 0 || accept5 != first_pop + 1) begin n_fail++; $display("FAIL full_fifth_accept: got cycle %0d want %0d", accept5, first_pop + 1); end
    n_cmp++; if (npop != 5) begin n_fail++; $display("FAIL full_pop_count: got %0d want 5", npop); end
  endtask

  task automatic test_route_order();
    int req = -1;
    int expected;
`ifdef IPC_YX_ROUTING_EN
    expected = 3;
`else
    expected = 1;
`endif
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0); in_flit = {T_HT, 8'h0B};
      if (routeReserveRequestValid && req < 0) req = int'(routeReserveRequest);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (req != expected) begin n_fail++; $display("FAIL route_order: got %0d want %0d", req, expected); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    logic relieve_seen = 1'b0;
    logic req_seen = 1'b0;
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_flit = {T_HEAD, 8'h0D};
    tick();
    in_valid = 1'b0;
    while (!out_valid && c < 20) begin tick(); c++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_forward: got out_valid=%b want 1", out_valid); end
    rst = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || routeReserveRequestValid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_immediate: got valid=%b ready=%b reqv=%b want 0 1 0", out_valid, in_ready, routeReserveRequestValid);
    end
    repeat (3) begin tick(); relieve_seen |= routeRelieve; end
    rst = 1'b1;
    repeat (5) begin tick(); relieve_seen |= routeRelieve; req_seen |= routeReserveRequestValid; end
    n_cmp++; if (relieve_seen !== 1'b0 || req_seen !== 1'b0) begin n_fail++; $display("FAIL midreset_after: got relieve=%b req=%b want 0 0", relieve_seen, req_seen); end
  endtask

  task automatic test_random();
    logic [FW-1:0] send_q[$];
    logic [FW-1:0] exp_q[$];
    int route_q[$];
    logic [FW-1:0] f;
    int n_stray = 0, drops = 0, idx = 0, cnt = 0, done = 0, len, dx, dy, e;
    logic prev_rv = 1'b0, tail_prev = 1'b0, pushed, popped;
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 2) == 0) begin
        send_q.push_back({($urandom_range(0, 1) == 1) ? T_TAIL : T_BODY, 8'($urandom)});
        n_stray++;
      end
      dx = $urandom_range(0, 3); dy = $urandom_range(0, 3); len = $urandom_range(1, 4);
      route_q.push_back(ref_route(dx, dy));
      f = {(len == 1) ? T_HT : T_HEAD, 4'($urandom), 2'(dx), 2'(dy)};
      send_q.push_back(f); exp_q.push_back(f);
      for (int b = 1; b < len; b++) begin
        f = {(b == len - 1) ? T_TAIL : T_BODY, 8'($urandom)};
        send_q.push_back(f); exp_q.push_back(f);
      end
    end
    apply_reset();
    for (int cyc = 0; cyc < 4000 && done < 4; cyc++) begin
      in_valid = (idx < send_q.size()) && ($urandom_range(0, 3) != 0);
      in_flit = (idx < send_q.size()) ? send_q[idx] : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (routeReserveRequestValid && !prev_rv) begin
        n_cmp++;
        if (route_q.size() == 0) begin n_fail++; $display("FAIL rand_route: got %0d want no request", routeReserveRequest); end
        else begin
          e = route_q.pop_front();
          if (routeReserveRequest !== 3'(e)) begin n_fail++; $display("FAIL rand_route: got %0d want %0d", routeReserveRequest, e); end
        end
      end
      prev_rv = routeReserveRequestValid;
      n_cmp++; if (routeRelieve !== tail_prev) begin n_fail++; $display("FAIL rand_relieve: got %b want %b", routeRelieve, tail_prev); end
      pushed = in_valid && in_ready;
      popped = out_valid && out_ready;
      if (popped) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_flit: got %h want nothing", out_flit); end
        else begin
          f = exp_q.pop_front();
          if (out_flit !== f) begin n_fail++; $display("FAIL rand_flit: got %h want %h", out_flit, f); end
        end
      end
      tail_prev = popped && out_flit[FW-1];
      tick();
      if (pushed) begin idx++; cnt++; end
      if (popped) cnt--;
      if (flitDropped) begin drops++; cnt--; end
      n_cmp++; if (in_ready !== (cnt < FD)) begin n_fail++; $display("FAIL rand_in_ready: got %b want %b (occupancy %0d)", in_ready, (cnt < FD), cnt); end
      if (idx == send_q.size() && exp_q.size() == 0) done++;
    end
    in_valid = 1'b0;
    n_cmp++; if (done < 4) begin n_fail++; $display("FAIL rand_timeout: got %0d flits left want 0", exp_q.size()); end
    n_cmp++; if (drops != n_stray) begin n_fail++; $display("FAIL rand_drops: got %0d want %0d", drops, n_stray); end
    n_cmp++; if (route_q.size() != 0 || cnt != 0) begin n_fail++; $display("FAIL rand_leftover: got routes=%0d occupancy=%0d want 0 0", route_q.size(), cnt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_packet();
    test_stray();
    test_full();
    test_route_order();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
